// File: rtl/systolic_pkg.sv
// Shared widths, drain FSM states and sizing helper for the systolic result path.
package systolic_pkg;
    localparam int DATA_WIDTH   = 8;
    localparam int RESULT_WIDTH = 16;
    localparam int OUT_WIDTH    = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } drain_state_e;

    // Index width that stays at least one bit for degenerate dimensions.
    function automatic int clog2_min1(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction
endpackage

// File: rtl/requant_sat.sv
// Combinational requantizer: arithmetic right shift (floor) then signed saturation.
module requant_sat #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 8,
    parameter int SHIFT = 0
) (
    input  logic signed [IN_W-1:0]  in_i,
    output logic signed [OUT_W-1:0] out_o,
    output logic                    sat_o
);
    localparam logic signed [IN_W-1:0] MAX_V = IN_W'((longint'(1) <<< (OUT_W-1)) - 1);
    localparam logic signed [IN_W-1:0] MIN_V = IN_W'(-(longint'(1) <<< (OUT_W-1)));

    logic signed [IN_W-1:0] v;

    always_comb begin
        v     = in_i >>> SHIFT;
        out_o = v[OUT_W-1:0];
        sat_o = 1'b0;
        if (v > MAX_V) begin
            out_o = MAX_V[OUT_W-1:0];
            sat_o = 1'b1;
        end else if (v < MIN_V) begin
            out_o = MIN_V[OUT_W-1:0];
            sat_o = 1'b1;
        end
    end
endmodule

// File: rtl/systolic_result_drain.sv
// Snapshots the multiplier result matrix on done and streams it out row-major,
// requantized, over valid/ready; a completion during a drain sets sticky overrun.
module systolic_result_drain #(
    parameter int  RESULT_WIDTH = systolic_pkg::RESULT_WIDTH,
    parameter int  M            = 8,
    parameter int  P            = 8,
    parameter int  OUT_WIDTH    = systolic_pkg::OUT_WIDTH,
    parameter int  SHIFT        = 0,
    localparam int RW           = systolic_pkg::clog2_min1(M),
    localparam int CW           = systolic_pkg::clog2_min1(P)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          done_in,
    input  logic [M*P*RESULT_WIDTH-1:0]   result_c,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic signed [OUT_WIDTH-1:0]   out_data,
    output logic [RW-1:0]                 out_row,
    output logic [CW-1:0]                 out_col,
    output logic                          out_last,
    output logic                          out_sat,
    output logic                          busy,
    output logic                          overrun,
    input  logic                          clear_err
);
    import systolic_pkg::*;

    drain_state_e state_q, state_d;
    logic [RW-1:0] row_q, row_d;
    logic [CW-1:0] col_q, col_d;
    logic          done_q;
    logic          overrun_q, overrun_d;
    logic [M-1:0][P-1:0][RESULT_WIDTH-1:0] buf_q;

    logic done_rise, capture, ovr_set, at_last, drain;
    logic signed [OUT_WIDTH-1:0] q_data;
    logic                        q_sat;

    assign done_rise = done_in & ~done_q;
    assign drain     = (state_q == DRAIN);
    assign at_last   = (row_q == RW'(M-1)) && (col_q == CW'(P-1));

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        capture = 1'b0;
        ovr_set = 1'b0;
        case (state_q)
            IDLE: begin
                if (done_rise) begin
                    capture = 1'b1;
                    state_d = DRAIN;
                    row_d   = '0;
                    col_d   = '0;
                end
            end
            DRAIN: begin
                if (out_ready) begin
                    if (at_last) begin
                        // A completion landing on the final handshake chains straight into a new drain.
                        row_d = '0;
                        col_d = '0;
                        if (done_rise) capture = 1'b1;
                        else           state_d = IDLE;
                    end else if (col_q == CW'(P-1)) begin
                        col_d = '0;
                        row_d = row_q + 1'b1;
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end
                if (done_rise && !(out_ready && at_last)) ovr_set = 1'b1;
            end
            default: state_d = IDLE;
        endcase
        overrun_d = ovr_set | (overrun_q & ~clear_err);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            row_q     <= '0;
            col_q     <= '0;
            done_q    <= 1'b1;
            overrun_q <= 1'b0;
            buf_q     <= '0;
        end else begin
            state_q   <= state_d;
            row_q     <= row_d;
            col_q     <= col_d;
            done_q    <= done_in;
            overrun_q <= overrun_d;
            if (capture) buf_q <= result_c;
        end
    end

    requant_sat #(
        .IN_W  (RESULT_WIDTH),
        .OUT_W (OUT_WIDTH),
        .SHIFT (SHIFT)
    ) u_requant (
        .in_i  (buf_q[row_q][col_q]),
        .out_o (q_data),
        .sat_o (q_sat)
    );

    assign out_valid = drain;
    assign busy      = drain;
    assign out_row   = row_q;
    assign out_col   = col_q;
    assign out_last  = drain & at_last;
    assign out_sat   = drain & q_sat;
    assign out_data  = drain ? q_data : '0;
    assign overrun   = overrun_q;
endmodule

// File: tb/tb_systolic_result_drain.sv
// Randomized bench: three drains (SHIFT 0,1,2) share stimulus and are checked every
// cycle against a queue/array model of the snapshot-and-stream behaviour.
module tb_systolic_result_drain;
    localparam int N = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic done_in = 1'b0;
    logic out_ready = 1'b1;
    logic clear_err = 1'b0;
    logic [N*16-1:0] result_c = '0;

    logic       ov[3], olast[3], os[3], ob[3], oo[3];
    logic [7:0] od[3];
    logic [2:0] orow[3], ocol[3];

    int vectors = 0;
    int miscompares = 0;

    // model state
    int m_snap[N];
    int m_idx = 0;
    bit m_active = 0, m_ovr = 0, m_prev = 1;

    int rec_d[3][N], rec_s[3][N];
    int beats = 0, last_data = 0;
    bit pstall[3];
    int pd[3], prow[3], pcol[3], plast[3], psat[3];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        systolic_result_drain #(.SHIFT(g)) u_dut (
            .clk(clk), .rst(rst), .done_in(done_in), .result_c(result_c),
            .out_valid(ov[g]), .out_ready(out_ready), .out_data(od[g]),
            .out_row(orow[g]), .out_col(ocol[g]), .out_last(olast[g]),
            .out_sat(os[g]), .busy(ob[g]), .overrun(oo[g]), .clear_err(clear_err)
        );
    end

    task automatic chk(input string nm, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // compare, then advance the model with the inputs the next edge will sample
    always @(negedge clk) begin
        int e, v, xd, xs;
        bit rise, fin, was_active;
        if (rst) begin
            m_active = 0; m_idx = 0; m_ovr = 0; m_prev = 1;
            for (int k = 0; k < N; k++) m_snap[k] = 0;
        end
        for (int k = 0; k < 3; k++) begin
            chk("valid", ov[k], m_active);
            chk("busy", ob[k], m_active);
            chk("overrun", oo[k], m_ovr);
            if (rst) begin
                chk("rst_data", $signed(od[k]), 0);
                chk("rst_row", orow[k], 0);
                chk("rst_col", ocol[k], 0);
                chk("rst_last", olast[k], 0);
                chk("rst_sat", os[k], 0);
            end else if (m_active) begin
                e = m_snap[m_idx];
                v = e >>> k;
                if (v > 127)       begin xd = 127;  xs = 1; end
                else if (v < -128) begin xd = -128; xs = 1; end
                else               begin xd = v;    xs = 0; end
                chk("data", $signed(od[k]), xd);
                chk("sat", os[k], xs);
                chk("row", orow[k], m_idx / 8);
                chk("col", ocol[k], m_idx % 8);
                chk("last", olast[k], (m_idx == N-1) ? 1 : 0);
                if (pstall[k]) begin
                    chk("stall_data", $signed(od[k]), pd[k]);
                    chk("stall_row", orow[k], prow[k]);
                    chk("stall_col", ocol[k], pcol[k]);
                    chk("stall_last", olast[k], plast[k]);
                    chk("stall_sat", os[k], psat[k]);
                end
                if (out_ready) begin
                    rec_d[k][m_idx] = $signed(od[k]);
                    rec_s[k][m_idx] = os[k];
                end
            end
            pstall[k] = !rst && ov[k] && !out_ready;
            pd[k] = $signed(od[k]); prow[k] = orow[k]; pcol[k] = ocol[k];
            plast[k] = olast[k]; psat[k] = os[k];
        end
        if (!rst && ov[0] && out_ready) begin
            beats++;
            if (olast[0]) last_data = $signed(od[0]);
        end
        if (!rst) begin
            rise = done_in && !m_prev;
            fin = m_active && out_ready && (m_idx == N-1);
            was_active = m_active;
            if (m_active && out_ready) begin
                if (m_idx == N-1) begin m_active = 0; m_idx = 0; end
                else m_idx++;
            end
            if (rise && (!was_active || fin)) begin
                for (int k = 0; k < N; k++) m_snap[k] = $signed(result_c[k*16 +: 16]);
                m_idx = 0;
                m_active = 1;
            end
            if (rise && was_active && !fin) m_ovr = 1;
            else if (clear_err)             m_ovr = 0;
            m_prev = done_in;
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic pulse_done();
        done_in = 1'b1; tick(); done_in = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (ob[0] && n < budget) begin tick(); n++; end
        chk("drain_done", ob[0], 0);
    endtask

    task automatic wait_idx(input int target, input int budget);
        int n = 0;
        while (!(ov[0] && (int'(orow[0]) * 8 + int'(ocol[0]) == target)) && n < budget) begin
            tick(); n++;
        end
        chk("reach_idx", ov[0] ? int'(orow[0]) * 8 + int'(ocol[0]) : -1, target);
    endtask

    task automatic fill_random();
        for (int k = 0; k < N; k++) result_c[k*16 +: 16] = 16'($urandom);
    endtask

    initial begin
        tick(); tick(); tick();
        rst = 1'b0;
        tick();

        // identity-ish matrix, ready held high
        result_c = '0;
        for (int i = 0; i < 8; i++) result_c[(i*8+i)*16 +: 16] = 16'd1;
        result_c[0 +: 16]        = 16'd5;
        result_c[(N-1)*16 +: 16] = 16'(-7);
        beats = 0;
        pulse_done();
        chk("busy_after_capture", ob[0], 1);
        wait_idle(200);
        chk("ident_beats", beats, 64);
        chk("ident_last_data", last_data, -7);
        chk("ident_first", rec_d[0][0], 5);
        chk("ident_diag", rec_d[0][9], 1);

        // saturation and shift corner values
        fill_random();
        result_c[0*16 +: 16] = 16'd300;
        result_c[1*16 +: 16] = 16'(-300);
        result_c[2*16 +: 16] = 16'(-128);
        result_c[3*16 +: 16] = 16'(-5);
        result_c[4*16 +: 16] = 16'd255;
        result_c[5*16 +: 16] = 16'd1000;
        pulse_done();
        wait_idle(200);
        chk("sat_pos_d", rec_d[0][0], 127);   chk("sat_pos_s", rec_s[0][0], 1);
        chk("sat_neg_d", rec_d[0][1], -128);  chk("sat_neg_s", rec_s[0][1], 1);
        chk("min_d", rec_d[0][2], -128);      chk("min_s", rec_s[0][2], 0);
        chk("sh1_neg5", rec_d[1][3], -3);     chk("sh1_neg5_s", rec_s[1][3], 0);
        chk("sh1_255", rec_d[1][4], 127);     chk("sh1_255_s", rec_s[1][4], 0);
        chk("sh2_1000", rec_d[2][5], 127);    chk("sh2_1000_s", rec_s[2][5], 1);

        // backpressure with random ready
        for (int r = 0; r < 3; r++) begin
            int n = 0;
            fill_random();
            beats = 0;
            pulse_done();
            while (ob[0] && n < 1000) begin
                out_ready = 1'($urandom % 2);
                tick(); n++;
            end
            out_ready = 1'b1;
            chk("bp_done", ob[0], 0);
            chk("bp_beats", beats, 64);
        end

        // overrun mid-drain, set beating a simultaneous clear
        fill_random();
        pulse_done();
        wait_idx(10, 200);
        fill_random();
        done_in = 1'b1; clear_err = 1'b1;
        tick();
        done_in = 1'b0; clear_err = 1'b0;
        chk("ovr_set", oo[0], 1);
        wait_idle(200);
        chk("ovr_sticky", oo[0], 1);
        clear_err = 1'b1; tick(); clear_err = 1'b0;
        chk("ovr_clear", oo[0], 0);

        // completion exactly on the final handshake
        pulse_done();
        wait_idx(63, 200);
        fill_random();
        done_in = 1'b1;
        tick();
        done_in = 1'b0;
        chk("chain_busy", ob[0], 1);
        chk("chain_row", orow[0], 0);
        chk("chain_col", ocol[0], 0);
        chk("chain_ovr", oo[0], 0);
        wait_idle(200);
        chk("chain_ovr_end", oo[0], 0);

        // reset mid-drain with done held high through release
        fill_random();
        pulse_done();
        wait_idx(20, 200);
        rst = 1'b1; done_in = 1'b1;
        #1;
        chk("rst_abort_valid", ov[0], 0);
        chk("rst_abort_busy", ob[0], 0);
        tick(); tick();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        chk("held_done_no_capture", ob[0], 0);
        done_in = 1'b0; tick();
        fill_random();
        done_in = 1'b1; tick();
        chk("recapture_busy", ob[0], 1);
        done_in = 1'b0;
        wait_idle(200);

        tick(); tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
